obstacle_scheduler: RTL and testbench

Generates the three-lane obstacle field that the scoring/collision logic consumes. Spawns new rows from an LFSR and shifts them toward the player at a step rate that speeds up over time, using the same schedule as the score counter. Sequences the game through idle, run and frozen phases. Sits between the top-level input/clock-divider logic and the collision/score block, whose `obstacle4` input is driven from this block's `obstacle4` output.

---
 rtl/obstacle_scheduler.sv | 139 +++++++++++++
 tb/tb_obstacle_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_scheduler.sv
// Three-lane obstacle field generator: LFSR-driven row spawning, a row shifter whose
// step interval shrinks over time, and the IDLE/RUN/FROZEN game phase sequencer.
`timescale 1ns/1ps
module obstacle_scheduler #(
  parameter int unsigned START_TICKS_PER_STEP = 100,
  parameter int unsigned END_TICKS_PER_STEP   = 20,
  parameter int unsigned TICKS_TO_SPEEDUP     = 750,
  parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
  input  logic       fast_hz,
  input  logic       rst,
  input  logic       start,
  input  logic       game_over,
  output logic [2:0] obstacle0,
  output logic [2:0] obstacle1,
  output logic [2:0] obstacle2,
  output logic [2:0] obstacle3,
  output logic [2:0] obstacle4,
  output logic       step,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FROZEN = 2'b10
  } state_t;

  localparam logic [31:0] C_START_TPS   = 32'(START_TICKS_PER_STEP);
  localparam logic [31:0] C_END_TPS     = 32'(END_TICKS_PER_STEP);
  localparam logic [31:0] C_SPEEDUP_MAX = 32'(TICKS_TO_SPEEDUP - 1);

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [31:0] r_step_cnt;
  logic [31:0] r_speed_cnt;
  logic [31:0] r_ticks_per_step;
  logic [2:0]  r_row [5];
  logic        r_step;

  logic        w_lfsr_fb;
  logic [2:0]  w_cand;
  logic [2:0]  w_new_row;
  logic        w_step_due;
  logic        w_speed_due;

  assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_cand      = r_lfsr[2:0];
  // >= rather than == so a speedup landing mid-interval still terminates the step.
  assign w_step_due  = (r_step_cnt >= (r_ticks_per_step - 32'd1));
  assign w_speed_due = (r_speed_cnt >= C_SPEEDUP_MAX);

  // A fully blocked row is never emitted, and any obstacle row is followed by a gap row.
  always_comb begin
    w_new_row = w_cand;
    if (r_row[0] != 3'b000) begin
      w_new_row = 3'b000;
    end else if (w_cand == 3'b111) begin
      case (r_lfsr[4:3])
        2'd1:    w_new_row = 3'b101;
        2'd2:    w_new_row = 3'b011;
        default: w_new_row = 3'b110;
      endcase
    end
  end

  always_ff @(posedge fast_hz or posedge rst) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_lfsr           <= LFSR_SEED;
      r_step_cnt       <= 32'd0;
      r_speed_cnt      <= 32'd0;
      r_ticks_per_step <= C_START_TPS;
      r_step           <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        r_row[i] <= 3'b000;
      end
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      r_step <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_step_cnt       <= 32'd0;
          r_speed_cnt      <= 32'd0;
          r_ticks_per_step <= C_START_TPS;
          for (int i = 0; i < 5; i++) begin
            r_row[i] <= 3'b000;
          end
          if (start) begin
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (game_over) begin
            r_state <= ST_FROZEN;
          end else begin
            if (w_step_due) begin
              r_step_cnt <= 32'd0;
              r_step     <= 1'b1;
              r_row[0]   <= w_new_row;
              for (int i = 1; i < 5; i++) begin
                r_row[i] <= r_row[i-1];
              end
            end else begin
              r_step_cnt <= r_step_cnt + 32'd1;
            end

            if (w_speed_due) begin
              r_speed_cnt <= 32'd0;
              if (r_ticks_per_step > C_END_TPS) begin
                r_ticks_per_step <= r_ticks_per_step - 32'd1;
              end
            end else begin
              r_speed_cnt <= r_speed_cnt + 32'd1;
            end
          end
        end

        ST_FROZEN: begin
          r_state <= ST_FROZEN;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign obstacle0 = r_row[0];
  assign obstacle1 = r_row[1];
  assign obstacle2 = r_row[2];
  assign obstacle3 = r_row[3];
  assign obstacle4 = r_row[4];
  assign step      = r_step;
  assign state     = r_state;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: reference LFSR, closed-form step schedule and a
// scoreboard of expected spawned rows, checked every cycle on the falling edge.
`timescale 1ns/1ps
module tb_obstacle_scheduler;

  localparam int          START_TPS = 100;
  localparam int          END_TPS   = 20;
  localparam int          SPEEDUP   = 750;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic       fast_hz = 1'b0;
  logic       rst;
  logic       start;
  logic       game_over;
  logic [2:0] obstacle0, obstacle1, obstacle2, obstacle3, obstacle4;
  logic       step;
  logic [1:0] state;

  obstacle_scheduler #(
    .START_TICKS_PER_STEP (START_TPS),
    .END_TICKS_PER_STEP   (END_TPS),
    .TICKS_TO_SPEEDUP     (SPEEDUP),
    .LFSR_SEED            (SEED)
  ) dut (
    .fast_hz   (fast_hz),
    .rst       (rst),
    .start     (start),
    .game_over (game_over),
    .obstacle0 (obstacle0),
    .obstacle1 (obstacle1),
    .obstacle2 (obstacle2),
    .obstacle3 (obstacle3),
    .obstacle4 (obstacle4),
    .step      (step),
    .state     (state)
  );

  always #5 fast_hz = ~fast_hz;

  int total = 0;
  int bad   = 0;

  // Reference LFSR; m_prev holds the value the design saw at the most recent edge.
  logic [15:0] m_lfsr;
  logic [15:0] m_prev;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge fast_hz or posedge rst) begin
    if (rst) begin
      m_lfsr <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_next(m_lfsr);
    end
  end

  function automatic logic [2:0] row_of(input logic [15:0] l, input logic [2:0] prev0);
    if (prev0 != 3'b000) return 3'b000;
    if (l[2:0] == 3'b111) begin
      case (l[4:3])
        2'd1:    return 3'b101;
        2'd2:    return 3'b011;
        default: return 3'b110;
      endcase
    end
    return l[2:0];
  endfunction

  // Ticks-per-step in force before RUN edge e (edges numbered from 1 after RUN entry).
  function automatic int tps_at(input int e);
    int t;
    t = START_TPS - (e - 1) / SPEEDUP;
    return (t < END_TPS) ? END_TPS : t;
  endfunction

  function automatic int next_step(input int ep);
    int e;
    e = ep + 1;
    while ((e - ep) < tps_at(e)) e++;
    return e;
  endfunction

  logic [2:0] obs [5];
  assign obs[0] = obstacle0;
  assign obs[1] = obstacle1;
  assign obs[2] = obstacle2;
  assign obs[3] = obstacle3;
  assign obs[4] = obstacle4;

  logic [2:0] exp_rows [5];
  logic [2:0] exp_q [$];
  logic [2:0] hist [$];
  bit         in_run, frozen, have_prev, seen99;
  logic [2:0] prev_obs0;
  int         run_edge, next_pred, last_obs_edge, steps_seen, first_step_edge;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) exp_rows[i] = 3'b000;
    exp_q.delete();
    hist.delete();
    in_run   = 0;
    frozen   = 0;
    run_edge = 0;
  endtask

  task automatic observe_step();
    int sp;
    steps_seen++;
    sp = run_edge - last_obs_edge;
    last_obs_edge = run_edge;
    if (steps_seen == 1) first_step_edge = run_edge;
    check("sb_pending", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) check("sb_row0", obstacle0, exp_q.pop_front());
    check("no111", 32'(obstacle0 != 3'b111), 1);
    if (have_prev && prev_obs0 != 3'b000) check("gap_row", obstacle0, 3'b000);
    prev_obs0 = obstacle0;
    have_prev = 1;
    hist.push_back(obstacle0);
    if (hist.size() >= 5) check("row4_hist", obstacle4, hist[hist.size()-5]);
    if (hist.size() > 8) void'(hist.pop_front());
    if (!seen99 && run_edge > SPEEDUP) begin
      seen99 = 1;
      check("spacing99", sp, 99);
    end
    if (run_edge > 60100) check("spacing20", sp, END_TPS);
  endtask

  // One clock: advances the model for the edge, then checks every output on the falling edge.
  task automatic tick();
    bit go, st, exp_step;
    logic [2:0] nr;
    logic [1:0] exp_state;
    go = game_over;
    st = start;
    exp_step = 0;
    @(posedge fast_hz);
    @(negedge fast_hz);
    if (in_run) begin
      if (go) begin
        in_run = 0;
        frozen = 1;
      end else begin
        run_edge++;
        if (run_edge == next_pred) begin
          nr = row_of(m_prev, exp_rows[0]);
          for (int i = 4; i > 0; i--) exp_rows[i] = exp_rows[i-1];
          exp_rows[0] = nr;
          exp_q.push_back(nr);
          exp_step  = 1;
          next_pred = next_step(run_edge);
        end
      end
    end else if (!frozen && st && !rst) begin
      in_run          = 1;
      run_edge        = 0;
      next_pred       = next_step(0);
      last_obs_edge   = 0;
      steps_seen      = 0;
      first_step_edge = -1;
      seen99          = 0;
      have_prev       = 0;
      hist.delete();
      exp_q.delete();
    end
    exp_state = frozen ? 2'b10 : (in_run ? 2'b01 : 2'b00);
    check("step", step, exp_step);
    check("state", state, exp_state);
    for (int i = 0; i < 5; i++) check($sformatf("row%0d", i), obs[i], exp_rows[i]);
    if (step === 1'b1) observe_step();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_state"}, state, 2'b00);
    check({tag, "_step"}, step, 1'b0);
    for (int i = 0; i < 5; i++) check($sformatf("%s_row%0d", tag, i), obs[i], 3'b000);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    game_over = 1'b0;
    model_reset();
    steps_seen = 0;
    first_step_edge = -1;
    #1 rst = 1'b1;
    repeat (3) tick();
    check_cleared("reset");
    rst = 1'b0;

    // Reset asserted between edges while a step pulse is high.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_entry", state, 2'b01);
    for (int i = 0; i < 400 && steps_seen < 3; i++) tick();
    check("rst_pre_step", step, 1'b1);
    #2 rst = 1'b1;
    #1 check_cleared("async_rst");
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    repeat (1000) tick();
    check_cleared("idle_hold");

    // Long run: first step, speedups, floor of 20 and row legality.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_entry2", state, 2'b01);
    for (int i = 0; i < 62000 && run_edge < 61000; i++) tick();
    check("first_step_at", first_step_edge, START_TPS);
    check("saw_speedup", 32'(seen99), 1);

    // Freeze exactly on a step boundary.
    for (int i = 0; i < 40 && step !== 1'b1; i++) tick();
    check("freeze_align", step, 1'b1);
    repeat (END_TPS - 1) tick();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check("freeze_state", state, 2'b10);
    check("freeze_step", step, 1'b0);
    check("freeze_rows", {obstacle4, obstacle3, obstacle2, obstacle1, obstacle0},
          {exp_rows[4], exp_rows[3], exp_rows[2], exp_rows[1], exp_rows[0]});
    for (int i = 0; i < 500; i++) begin
      start = (i % 2 == 0);
      tick();
    end
    start = 1'b0;
    check("frozen_hold_state", state, 2'b10);

    // Reset out of FROZEN restores the initial step interval.
    #2 rst = 1'b1;
    #1 check_cleared("frozen_rst");
    model_reset();
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_entry3", state, 2'b01);
    repeat (150) tick();
    check("restart_first_step", first_step_edge, START_TPS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
